sfifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one synchronous FIFO (the `sfifo_wrapper` instance in the DDR3 command/write-data path) among `NREQ` requesters. Each grant reserves room for a whole fixed-length burst, so a granted burst never stalls on FIFO full. Each stored word is tagged with the requester index so the downstream consumer can route it. The FIFO wrapper's own level counts are not meaningful, so the block keeps its own committed-occupancy counter.

---
 rtl/sfifo_wr_arb_pkg.sv | 16 +
 rtl/sfifo_wr_arbiter_rr_pick.sv | 34 +++
 rtl/sfifo_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_sfifo_wr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfifo_wr_arb_pkg.sv
// Shared types and constants for the sfifo write arbiter.
package sfifo_wr_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

    localparam int unsigned STATS_W = 16;

    // Saturating increment for the per-requester grant counters
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/sfifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int unsigned  w_pos;
    logic [IW-1:0] w_cand;

    // Scan N candidates starting at i_last+1 and keep the first hit
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_pos    = 0;
        w_cand   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_pos  = (32'(i_last) + k) % N;
            w_cand = IW'(w_pos);
            if (!o_any && i_req[w_cand]) begin
                o_onehot[w_cand] = 1'b1;
                o_idx            = w_cand;
                o_any            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin burst write arbiter in front of a shared synchronous FIFO.
// Each grant reserves BURST words, so a granted burst never sees FIFO full.
// Optional SFIFO_WR_ARB_STATS_EN adds per-requester saturating grant counters.
module sfifo_wr_arbiter
    import sfifo_wr_arb_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned DW    = 32,
    parameter  int unsigned DEPTH = 32,
    parameter  int unsigned BURST = 4,
    localparam int unsigned IDW   = $clog2(NREQ),
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*DW-1:0]   i_req_data,
    output logic [NREQ-1:0]      o_req_ready,
    output logic                 o_fifo_wr_en,
    output logic [IDW+DW-1:0]    o_fifo_din,
    input  logic                 i_fifo_rd_en,
    input  logic                 i_fifo_empty,
    input  logic                 i_fifo_full,
    output logic [NREQ-1:0]      o_grant,
    output logic [LW-1:0]        o_level,
    output logic                 o_err
`ifdef SFIFO_WR_ARB_STATS_EN
    ,
    output logic [NREQ*STATS_W-1:0] o_grant_cnt
`endif
);

    localparam int unsigned BCW = $clog2(BURST) + 1;

    arb_state_t       r_state;
    logic [NREQ-1:0]  r_grant;
    logic [IDW-1:0]   r_gidx;
    logic [IDW-1:0]   r_last;
    logic [LW-1:0]    r_level;
    logic [BCW-1:0]   r_beat;
    logic             r_err;

    logic [NREQ-1:0]  w_onehot;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic             w_pop;
    logic             w_dec;
    logic [LW-1:0]    w_level_pop;
    logic             w_admit;
    logic             w_beat;
    logic [DW-1:0]    w_data_g;

    rr_pick #(
        .N  (NREQ),
        .IW (IDW)
    ) u_rr_pick (
        .i_req    (i_req_valid),
        .i_last   (r_last),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    // Pop accounting, admission check and beat detection
    always_comb begin
        w_pop       = i_fifo_rd_en & ~i_fifo_empty;
        w_dec       = w_pop & (|r_level);
        w_level_pop = r_level - LW'(w_dec);
        w_admit     = (r_state == ST_IDLE) && w_any &&
                      ((LW'(DEPTH) - w_level_pop) >= LW'(BURST));
        w_beat      = (r_state == ST_XFER) && (|(i_req_valid & r_grant));
        w_data_g    = i_req_data[r_gidx*DW +: DW];
    end

    assign o_req_ready  = r_grant;
    assign o_fifo_wr_en = w_beat;
    assign o_fifo_din   = w_beat ? {r_gidx, w_data_g} : '0;
    assign o_grant      = r_grant;
    assign o_level      = r_level;
    assign o_err        = r_err;

    // Grant FSM, committed-level counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_last  <= IDW'(NREQ - 1);
            r_level <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_level <= w_level_pop + (w_admit ? LW'(BURST) : LW'(0));
            r_err   <= r_err | (w_beat & i_fifo_full) |
                       (w_pop & (r_level == '0)) |
                       (i_fifo_rd_en & i_fifo_empty);
            case (r_state)
                ST_IDLE: begin
                    if (w_admit) begin
                        r_grant <= w_onehot;
                        r_gidx  <= w_idx;
                        r_last  <= w_idx;
                        r_beat  <= '0;
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_beat) begin
                        if (r_beat == BCW'(BURST - 1)) begin
                            r_grant <= '0;
                            r_beat  <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_beat <= r_beat + BCW'(1);
                        end
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SFIFO_WR_ARB_STATS_EN
    logic [NREQ*STATS_W-1:0] r_grant_cnt;

    // One saturating counter per requester, bumped on each grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_cnt <= '0;
        end else begin
            for (int unsigned r = 0; r < NREQ; r++) begin
                if (w_admit && w_onehot[r]) begin
                    r_grant_cnt[r*STATS_W +: STATS_W] <= sat_inc(r_grant_cnt[r*STATS_W +: STATS_W]);
                end
            end
        end
    end

    assign o_grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// Bench for sfifo_wr_arbiter: transaction-level model plus directed literals.
module tb_sfifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int BURST = 4;
    localparam int IDW   = 2;
    localparam int LW    = 6;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       i_req_valid;
    logic [NREQ*DW-1:0]    i_req_data;
    logic [NREQ-1:0]       o_req_ready;
    logic                  o_fifo_wr_en;
    logic [IDW+DW-1:0]     o_fifo_din;
    logic                  i_fifo_rd_en;
    logic                  i_fifo_empty;
    logic                  i_fifo_full;
    logic [NREQ-1:0]       o_grant;
    logic [LW-1:0]         o_level;
    logic                  o_err;
`ifdef SFIFO_WR_ARB_STATS_EN
    logic [NREQ*16-1:0]    o_grant_cnt;
`endif

    always #5 clk = ~clk;

    sfifo_wr_arbiter #(
        .NREQ  (NREQ),
        .DW    (DW),
        .DEPTH (DEPTH),
        .BURST (BURST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .i_req_data   (i_req_data),
        .o_req_ready  (o_req_ready),
        .o_fifo_wr_en (o_fifo_wr_en),
        .o_fifo_din   (o_fifo_din),
        .i_fifo_rd_en (i_fifo_rd_en),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_full  (i_fifo_full),
        .o_grant      (o_grant),
        .o_level      (o_level),
        .o_err        (o_err)
`ifdef SFIFO_WR_ARB_STATS_EN
        ,
        .o_grant_cnt  (o_grant_cnt)
`endif
    );

    // Model state: committed level, last winner, current grant (-1 = none),
    // beats done, sticky error, and words physically held by the FIFO.
    int m_level  = 0;
    int m_last   = NREQ - 1;
    int m_g      = -1;
    int m_beat   = 0;
    bit m_err    = 1'b0;
    int m_stored = 0;
    bit force_full = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive FIFO flags, compare at negedge, advance model, step past posedge
    task automatic step();
        logic [NREQ-1:0]   eg;
        logic              ewr;
        logic [IDW+DW-1:0] edin;
        bit                pop;
        int                nl;
        i_fifo_empty = (m_stored == 0);
        i_fifo_full  = force_full || (m_stored >= DEPTH);
        @(negedge clk);
        eg   = (m_g >= 0) ? NREQ'(1 << m_g) : '0;
        ewr  = (m_g >= 0) && i_req_valid[m_g];
        edin = ewr ? {IDW'(m_g), i_req_data[m_g*DW +: DW]} : '0;
        chk("grant", 64'(o_grant), 64'(eg));
        chk("ready", 64'(o_req_ready), 64'(eg));
        chk("wr_en", 64'(o_fifo_wr_en), 64'(ewr));
        chk("din", 64'(o_fifo_din), 64'(edin));
        chk("level", 64'(o_level), 64'(m_level));
        chk("err", 64'(o_err), 64'(m_err));
        pop = i_fifo_rd_en && !i_fifo_empty;
        if (rst) begin
            m_level = 0; m_last = NREQ - 1; m_g = -1; m_beat = 0;
            m_err = 1'b0; m_stored = 0;
        end else begin
            m_err = m_err | (ewr && i_fifo_full) | (pop && m_level == 0) |
                    (i_fifo_rd_en && i_fifo_empty);
            nl = (pop && m_level > 0) ? m_level - 1 : m_level;
            if (m_g < 0) begin
                if (i_req_valid != 0 && (DEPTH - nl) >= BURST) begin
                    for (int k = 1; k <= NREQ; k++) begin
                        int c;
                        c = (m_last + k) % NREQ;
                        if (m_g < 0 && i_req_valid[c]) m_g = c;
                    end
                    m_last = m_g;
                    m_beat = 0;
                    nl += BURST;
                end
            end else if (ewr) begin
                m_beat++;
                if (m_beat == BURST) m_g = -1;
            end
            m_level  = nl;
            m_stored = m_stored + (ewr ? 1 : 0) - (pop ? 1 : 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req_valid = '0;
        i_fifo_rd_en = 1'b0;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic rand_data();
        for (int r = 0; r < NREQ; r++) i_req_data[r*DW +: DW] = $urandom;
    endtask

    logic [NREQ-1:0] order_q[$];
    logic [NREQ-1:0] exp_order[8];
    logic [NREQ-1:0] prev_g;
    logic [31:0]     dv;

    initial begin
        rst = 1'b1;
        i_req_valid = '0;
        i_req_data = '0;
        i_fifo_rd_en = 1'b0;
        i_fifo_empty = 1'b1;
        i_fifo_full = 1'b0;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        // Reset state and single burst from requester 0
        do_reset();
        chk("rst_grant", 64'(o_grant), 64'd0);
        chk("rst_level", 64'(o_level), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_wr_en", 64'(o_fifo_wr_en), 64'd0);
        i_req_valid = 4'b0001;
        i_req_data[31:0] = 32'hA0;
        step();
        chk("t1_grant", 64'(o_grant), 64'h1);
        chk("t1_level", 64'(o_level), 64'd4);
        for (int b = 0; b < 4; b++) begin
            dv = 32'hA0 + 32'(b);
            i_req_data[31:0] = dv;
            #1;
            chk("t1_din", 64'(o_fifo_din), 64'({2'b00, dv}));
            step();
        end
        i_req_valid = '0;
        #1;
        chk("t1_grant_end", 64'(o_grant), 64'h0);
        chk("t1_level_end", 64'(o_level), 64'd4);

        // All requesters busy, no reads: rotation then fill-up stall
        do_reset();
        i_req_valid = 4'hF;
        prev_g = '0;
        for (int c = 0; c < 50; c++) begin
            rand_data();
            step();
            if (o_grant != 0 && prev_g == 0) order_q.push_back(o_grant);
            prev_g = o_grant;
        end
        chk("t2_nbursts", 64'(order_q.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            chk("t2_order", 64'((i < order_q.size()) ? order_q[i] : 4'b0), 64'(exp_order[i]));
        chk("t2_level", 64'(o_level), 64'd32);
        chk("t2_stall", 64'(o_grant), 64'h0);

        // Admission boundary: pops enable a grant in the same decision
        i_req_valid = '0;
        i_fifo_rd_en = 1'b1;
        step(); step();
        chk("t3_level30", 64'(o_level), 64'd30);
        i_req_valid = 4'b0100;
        i_fifo_rd_en = 1'b0;
        step();
        chk("t3_nogrant_a", 64'(o_grant), 64'h0);
        i_fifo_rd_en = 1'b1;
        step();
        chk("t3_level29", 64'(o_level), 64'd29);
        chk("t3_nogrant_b", 64'(o_grant), 64'h0);
        step();
        chk("t3_grant", 64'(o_grant), 64'h4);
        chk("t3_level32", 64'(o_level), 64'd32);
        i_fifo_rd_en = 1'b0;
        for (int b = 0; b < 4; b++) begin rand_data(); step(); end
        chk("t3_done", 64'(o_grant), 64'h0);

        // Valid gap inside a burst holds the grant
        do_reset();
        i_req_valid = 4'b0010;
        step();
        rand_data(); step();
        rand_data(); step();
        i_req_valid = '0;
        for (int g = 0; g < 5; g++) begin
            step();
            chk("t4_ready_held", 64'(o_req_ready), 64'h2);
        end
        i_req_valid = 4'b0010;
        rand_data(); step();
        rand_data(); step();
        i_req_valid = '0;
        #1;
        chk("t4_released", 64'(o_grant), 64'h0);

        // Reset in the middle of a burst
        do_reset();
        i_req_valid = 4'b0001;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t5_grant", 64'(o_grant), 64'h0);
        chk("t5_level", 64'(o_level), 64'd0);
        chk("t5_wr_en", 64'(o_fifo_wr_en), 64'd0);
        i_req_valid = '0;
        step();

        // Write into a full FIFO sets the sticky error
        do_reset();
        i_req_valid = 4'b0001;
        step();
        force_full = 1'b1;
        step();
        force_full = 1'b0;
        chk("t6_err_set", 64'(o_err), 64'd1);
        for (int c = 0; c < 5; c++) step();
        chk("t6_err_held", 64'(o_err), 64'd1);
        do_reset();
        chk("t6_err_clr", 64'(o_err), 64'd0);

`ifdef SFIFO_WR_ARB_STATS_EN
        do_reset();
        i_req_valid = 4'b0010;
        for (int c = 0; c < 14; c++) step();
        chk("stats_cnt1", 64'(o_grant_cnt[31:16]), 64'd3);
        i_req_valid = '0;
`endif

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            i_req_valid = NREQ'($urandom_range(0, 15));
            rand_data();
            i_fifo_rd_en = (m_stored > 0) && ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
